// File: rtl/cycle_averager.sv
// Point-wise cycle averager: sums n_avg framed cycles bin-by-bin in an internal RAM
// and streams the completed per-bin sums out through a RAM-style write port.
module cycle_averager #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 13,
    parameter int ACC_WIDTH  = 32,
    parameter int SLOW_WIDTH = 19
) (
    input  logic                         clk,
    input  logic                         sclr,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [ADDR_WIDTH-1:0]        period,
    input  logic [SLOW_WIDTH-1:0]        n_avg,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    output logic                         busy,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [ACC_WIDTH-1:0]         wr_data,
    output logic                         done,
    output logic [SLOW_WIDTH-1:0]        cycle_index
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] period_r;
    logic [SLOW_WIDTH-1:0] navg_r;
    logic                  cont_r;
    logic [ADDR_WIDTH-1:0] bin_r;
    logic [SLOW_WIDTH-1:0] cyc_r;

    logic accept;
    logic bin_last;
    logic cyc_last;

    // din_valid has no back-pressure: every valid sample in RUN is taken on that edge.
    assign accept   = (state == RUN) && din_valid;
    assign bin_last = (bin_r == period_r);
    assign cyc_last = (cyc_r == navg_r - SLOW_WIDTH'(1));

    assign busy        = (state == RUN);
    assign cycle_index = cyc_r;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && bin_last && cyc_last && !cont_r) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            period_r <= '0;
            navg_r   <= SLOW_WIDTH'(1);
            cont_r   <= 1'b0;
            bin_r    <= '0;
            cyc_r    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                period_r <= period;
                navg_r   <= (n_avg == '0) ? SLOW_WIDTH'(1) : n_avg;
                cont_r   <= continuous;
                bin_r    <= '0;
                cyc_r    <= '0;
            end
        end else if (accept) begin
            if (bin_last) begin
                bin_r <= '0;
                cyc_r <= cyc_last ? '0 : cyc_r + SLOW_WIDTH'(1);
            end else begin
                bin_r <= bin_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Stage 0 holds the accepted sample while its RAM word is read.
    logic                  s0_valid, s0_first, s0_last, s0_final;
    logic [ADDR_WIDTH-1:0] s0_addr;
    logic [ACC_WIDTH-1:0]  s0_din;
    // Stage 1 adds and either writes back or emits the finished sum.
    logic                  s1_valid, s1_first, s1_last, s1_final;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [ACC_WIDTH-1:0]  s1_din;
    logic [ACC_WIDTH-1:0]  rd_q;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  wr_final;

    logic [ACC_WIDTH-1:0] acc_ram [0:(1<<ADDR_WIDTH)-1];

    assign sum = (s1_first ? '0 : rd_q) + s1_din;

    always_ff @(posedge clk) begin
        if (sclr) begin
            s0_valid <= 1'b0;
            s1_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_final <= 1'b0;
            s0_addr  <= '0;
            s0_din   <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_final <= 1'b0;
            s1_addr  <= '0;
            s1_din   <= '0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_addr  <= bin_r;
                s0_din   <= {{(ACC_WIDTH-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
                s0_first <= (cyc_r == '0);
                s0_last  <= cyc_last;
                s0_final <= cyc_last && bin_last;
            end
            s1_valid <= s0_valid;
            s1_addr  <= s0_addr;
            s1_din   <= s0_din;
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_final <= s0_final;
        end
    end

    // Back-to-back samples on the same bin must see the sum being written this edge.
    always_ff @(posedge clk) begin
        if (s1_valid && !s1_last) begin
            acc_ram[s1_addr] <= sum;
        end
        if (s0_valid) begin
            if (s1_valid && (s1_addr == s0_addr)) begin
                rd_q <= sum;
            end else begin
                rd_q <= acc_ram[s0_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_final <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_en    <= s1_valid && s1_last;
            wr_final <= s1_valid && s1_last && s1_final;
            if (s1_valid && s1_last) begin
                wr_addr <= s1_addr;
                wr_data <= sum;
            end
            done <= wr_final;
        end
    end

endmodule

// File: tb/tb_cycle_averager.sv
// Bench for cycle_averager: table vectors, hand sequences and random runs checked
// against a per-bin summing model with expected write/done edge times.
module tb_cycle_averager;

    localparam int DW   = 14;
    localparam int AW   = 6;
    localparam int ACCW = 16;
    localparam int SW   = 8;

    logic                 clk = 1'b0;
    logic                 sclr = 1'b1;
    logic                 start = 1'b0;
    logic                 continuous = 1'b0;
    logic [AW-1:0]        period = '0;
    logic [SW-1:0]        n_avg = '0;
    logic signed [DW-1:0] din = '0;
    logic                 din_valid = 1'b0;
    logic                 busy, wr_en, done;
    logic [AW-1:0]        wr_addr;
    logic [ACCW-1:0]      wr_data;
    logic [SW-1:0]        cycle_index;

    cycle_averager #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .SLOW_WIDTH(SW)
    ) dut (
        .clk(clk), .sclr(sclr), .start(start), .continuous(continuous),
        .period(period), .n_avg(n_avg), .din(din), .din_valid(din_valid),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .cycle_index(cycle_index)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [ACCW-1:0] data;
        int              cyc;
    } wr_t;

    wr_t             exp_q[$];
    int              done_q[$];
    logic [ACCW-1:0] obs_q[$];
    int              checks = 0;
    int              errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, edge_n);
        end
    endfunction

    // Scoreboard: every write and done must land on exactly the predicted edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            checks++; errors++;
            $display("FAIL wr_missing: no write at edge %0d, expected addr %0d data %0d",
                     exp_q[0].cyc, exp_q[0].addr, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
                if (wr_addr !== exp_q[0].addr || wr_data !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL wr_data: got addr %0d data %0d expected addr %0d data %0d",
                             wr_addr, wr_data, exp_q[0].addr, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else begin
                errors++;
                $display("FAIL wr_unexpected: got addr %0d data %0d at edge %0d expected no write",
                         wr_addr, wr_data, edge_n);
            end
            obs_q.push_back(wr_data);
        end
        while (done_q.size() > 0 && done_q[0] < edge_n) begin
            checks++; errors++;
            $display("FAIL done_missing: got no done expected one at edge %0d", done_q[0]);
            void'(done_q.pop_front());
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() > 0 && done_q[0] == edge_n) begin
                void'(done_q.pop_front());
            end else begin
                errors++;
                $display("FAIL done_unexpected: got done at edge %0d expected none", edge_n);
            end
        end
    end

    // gap: 0 always valid, 1 alternating, 2 random. start_at >= 0 pulses start mid-run.
    task automatic run(input int p, input int n, input bit cont, input int nsamp,
                       input int base, input int step, input int modv, input bit rnd,
                       input int gap, input int start_at, input bit drain);
        int n_eff, len, total, k, it, kr, b, c, v, ae;
        bit vld;
        logic [ACCW-1:0] sums [64];
        logic signed [DW-1:0] d;
        wr_t e;
        n_eff = (n == 0) ? 1 : n;
        len   = p + 1;
        total = len * n_eff;
        obs_q.delete();
        @(negedge clk);
        start = 1'b1; continuous = cont; period = AW'(p); n_avg = SW'(n);
        @(negedge clk);
        start = 1'b0; continuous = ~cont; period = AW'($urandom); n_avg = SW'($urandom);
        chk("busy_rise", busy, 1);
        k  = 0;
        it = 0;
        while (k < nsamp) begin
            case (gap)
                1:       vld = (it % 2 == 0);
                2:       vld = ($urandom_range(0, 2) != 0);
                default: vld = 1'b1;
            endcase
            it++;
            if (vld) begin
                if (rnd) begin
                    d = DW'($urandom);
                    v = int'(d);
                end else begin
                    v = base + step * (k % modv);
                end
                din = DW'(v);
                din_valid = 1'b1;
                if (cont || k < total) begin
                    kr = k % total;
                    c  = kr / len;
                    b  = kr % len;
                    ae = edge_n + 1;
                    sums[b] = ((c == 0) ? '0 : sums[b]) + ACCW'(v);
                    if (c == n_eff - 1) begin
                        e.addr = AW'(b); e.data = sums[b]; e.cyc = ae + 2;
                        exp_q.push_back(e);
                    end
                    if (kr == total - 1) done_q.push_back(ae + 3);
                end
                if (k == start_at) begin
                    start = 1'b1; period = AW'((p == 1) ? 3 : 1); n_avg = SW'(n + 3); continuous = 1'b1;
                end
                k++;
            end else begin
                din = DW'($urandom);
                din_valid = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            din_valid = 1'b0;
            if (vld && (cont || k < total)) chk("cycle_index", cycle_index, SW'((k % total) / len));
            if (vld && !cont && k == total) chk("busy_fall", busy, 0);
        end
        if (drain) begin
            repeat (5) @(negedge clk);
            chk("busy_end", busy, 32'(cont || nsamp < total));
            chk("exp_q_empty", exp_q.size(), 0);
            chk("done_q_empty", done_q.size(), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sclr = 1'b1; din_valid = 1'b0; start = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].cyc > edge_n) void'(exp_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > edge_n) void'(done_q.pop_back());
        @(negedge clk);
        sclr = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cycle_index", cycle_index, 0);
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        int              p, n, base, step, modv, gap, exp_cnt;
        logic [ACCW-1:0] exp_first, exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p, n, nn;
        vecs[0] = '{p: 3, n: 4, base: 1,     step: 1,  modv: 4,    gap: 0, exp_cnt: 4, exp_first: 16'd4,     exp_last: 16'd16};
        vecs[1] = '{p: 0, n: 5, base: -8192, step: 0,  modv: 1,    gap: 0, exp_cnt: 1, exp_first: 16'd24576, exp_last: 16'd24576};
        vecs[2] = '{p: 1, n: 2, base: 10,    step: 10, modv: 1000, gap: 1, exp_cnt: 2, exp_first: 16'd40,    exp_last: 16'd60};
        vecs[3] = '{p: 2, n: 0, base: 7,     step: 0,  modv: 1,    gap: 0, exp_cnt: 3, exp_first: 16'd7,     exp_last: 16'd7};
        vecs[4] = '{p: 2, n: 1, base: -5,    step: -1, modv: 1000, gap: 0, exp_cnt: 3, exp_first: 16'hFFFB,  exp_last: 16'hFFF9};

        repeat (3) @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_wr_en", wr_en, 0);
        chk("init_done", done, 0);
        chk("init_wr_addr", wr_addr, 0);
        chk("init_wr_data", wr_data, 0);
        chk("init_cycle_index", cycle_index, 0);
        sclr = 1'b0;

        for (int i = 0; i < 5; i++) begin
            nn = (vecs[i].n == 0) ? 1 : vecs[i].n;
            run(vecs[i].p, vecs[i].n, 1'b0, (vecs[i].p + 1) * nn + 2, vecs[i].base, vecs[i].step,
                vecs[i].modv, 1'b0, vecs[i].gap, -1, 1'b1);
            chk("vec_count", obs_q.size(), vecs[i].exp_cnt);
            if (obs_q.size() > 0) begin
                chk("vec_first", obs_q[0], vecs[i].exp_first);
                chk("vec_last", obs_q[$], vecs[i].exp_last);
            end
        end

        // start and period change mid-run must not disturb the latched run.
        run(4, 2, 1'b0, 10, 0, 0, 1, 1'b1, 0, 3, 1'b1);
        chk("start_ignored_count", obs_q.size(), 5);

        // Continuous with n_avg = 0, then reset with a write and done still in flight.
        run(2, 0, 1'b1, 9, 7, 0, 1, 1'b0, 0, -1, 1'b0);
        chk("busy_cont", busy, 1);
        do_reset();

        // Reset during cycle 1, then a fresh run over the stale RAM.
        run(3, 3, 1'b0, 6, 0, 0, 1, 1'b1, 2, -1, 1'b1);
        do_reset();
        run(3, 2, 1'b0, 9, 0, 0, 1, 1'b1, 0, -1, 1'b1);
        chk("fresh_count", obs_q.size(), 4);

        for (int i = 0; i < 8; i++) begin
            p  = $urandom_range(0, 7);
            n  = $urandom_range(0, 4);
            nn = (n == 0) ? 1 : n;
            run(p, n, 1'b0, (p + 1) * nn + 1, 0, 0, 1, 1'b1, 2, -1, 1'b1);
            chk("rand_count", obs_q.size(), p + 1);
        end

        p  = $urandom_range(0, 5);
        n  = $urandom_range(1, 3);
        run(p, n, 1'b1, (p + 1) * n * 2 + 1, 0, 0, 1, 1'b1, 2, -1, 1'b0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
